// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared ALU codes, writeback selects, flag indices and helpers
package processor_pkg;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'd0,
      ALU_ADDINC = 5'd1,
      ALU_INCA   = 5'd3,
      ALU_SUB    = 5'd5,
      ALU_DECA   = 5'd6,
      ALU_LSL    = 5'd8,
      ALU_ASR    = 5'd9,
      ALU_ZEROS  = 5'd10,
      ALU_AND    = 5'd11,
      ALU_PASSB  = 5'd13,
      ALU_PASSA  = 5'd15,
      ALU_XOR    = 5'd16,
      ALU_OR     = 5'd17
   } alu_op_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MEM = 2'b01,
      WB_PC1 = 2'b10,
      WB_IMM = 2'b11
   } wb_sel_e;

   localparam int FLAG_O = 0;
   localparam int FLAG_S = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_Z = 3;

   localparam int DMEM_AW    = 10;
   localparam int DMEM_DEPTH = 1 << DMEM_AW;

   // Places the four condition bits at their architectural positions.
   function automatic logic [3:0] pack_flags(input logic z, input logic c,
                                             input logic s, input logic o);
      logic [3:0] f;
      f         = '0;
      f[FLAG_Z] = z;
      f[FLAG_C] = c;
      f[FLAG_S] = s;
      f[FLAG_O] = o;
      return f;
   endfunction

endpackage

// File: rtl/ex_wb_if.sv
// rtl/ex_wb_if.sv - execute/writeback stage bus with driver (master) and stage (slave) views
interface ex_wb_if;

   logic        in_valid;
   logic [31:0] in_PRA;
   logic [31:0] in_PRB;
   logic [31:0] in_se_out;
   logic [31:0] in_PC;
   logic [3:0]  in_RA;
   logic [3:0]  in_RB;
   logic [3:0]  in_WC;
   logic        in_S_MXSE;
   logic [4:0]  in_OP_ALU;
   logic        in_W_DM;
   logic [1:0]  in_S_MXRB;
   logic        in_W_RB;

   logic [3:0]  out_flags;
   logic [31:0] out_WPC;
   logic [3:0]  out_WC;
   logic        out_W_RB;

   modport master (
      output in_valid, in_PRA, in_PRB, in_se_out, in_PC, in_RA, in_RB, in_WC,
             in_S_MXSE, in_OP_ALU, in_W_DM, in_S_MXRB, in_W_RB,
      input  out_flags, out_WPC, out_WC, out_W_RB
   );

   modport slave (
      input  in_valid, in_PRA, in_PRB, in_se_out, in_PC, in_RA, in_RB, in_WC,
             in_S_MXSE, in_OP_ALU, in_W_DM, in_S_MXRB, in_W_RB,
      output out_flags, out_WPC, out_WC, out_W_RB
   );

endinterface

// File: rtl/alu32.sv
// rtl/alu32.sv - 32-bit combinational ALU with Z/C/S/O flag generation
module alu32
   import processor_pkg::*;
(
   input  logic [4:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result,
   output logic [3:0]  flags,
   output logic        op_known
);

   alu_op_e     op_e;
   logic [31:0] add_b;
   logic        add_cin;
   logic [32:0] sum;
   logic        arith;
   logic        ovf;

   assign op_e = alu_op_e'(op);

   // All arithmetic codes share one adder; pick its second operand and carry-in.
   always_comb begin
      add_b   = b;
      add_cin = 1'b0;
      case (op_e)
         ALU_ADDINC: add_cin = 1'b1;
         ALU_INCA: begin
            add_b   = '0;
            add_cin = 1'b1;
         end
         ALU_SUB: begin
            add_b   = ~b;
            add_cin = 1'b1;
         end
         ALU_DECA: begin
            add_b   = '1;
            add_cin = 1'b0;
         end
         default: ;
      endcase
   end

   assign sum = {1'b0, a} + {1'b0, add_b} + {32'd0, add_cin};
   assign ovf = (a[31] == add_b[31]) && (sum[31] != a[31]);

   // Result select; unknown codes pass A through and are flagged as not updating flags.
   always_comb begin
      result   = a;
      arith    = 1'b0;
      op_known = 1'b1;
      case (op_e)
         ALU_ADD, ALU_ADDINC, ALU_INCA, ALU_SUB, ALU_DECA: begin
            result = sum[31:0];
            arith  = 1'b1;
         end
         ALU_LSL:   result = {a[30:0], 1'b0};
         ALU_ASR:   result = {a[31], a[31:1]};
         ALU_ZEROS: result = '0;
         ALU_AND:   result = a & b;
         ALU_PASSB: result = b;
         ALU_PASSA: result = a;
         ALU_XOR:   result = a ^ b;
         ALU_OR:    result = a | b;
         default:   op_known = 1'b0;
      endcase
   end

   // Carry and overflow are meaningful only for adder codes; logic/shift codes clear them.
   assign flags = pack_flags(result == 32'd0, arith & sum[32], result[31], arith & ovf);

endmodule

// File: rtl/ex_wb.sv
// rtl/ex_wb.sv - execute/writeback stage: ALU, 1Kx32 data memory, result registers (EX_WB_FWD_EN enables operand forwarding)
module ex_wb
   import processor_pkg::*;
(
   input  logic   CLK,
   input  logic   RESET,
   ex_wb_if.slave bus
);

   logic [31:0] mem [DMEM_DEPTH];

   logic [3:0]  flags_q, flags_d;
   logic [31:0] wpc_q, wpc_d;
   logic [3:0]  wc_q, wc_d;
   logic        w_rb_q, w_rb_d;
   wb_sel_e     sel_q, sel_d;
   logic [31:0] rd_data_q, rd_data_d;

   logic [31:0] op_a;
   logic [31:0] op_b_reg;
   logic [31:0] op_b;
   logic [31:0] alu_res;
   logic [3:0]  alu_flags;
   logic        alu_known;
   logic [31:0] wpc_out;
   logic [31:0] wb_data;
   logic [DMEM_AW-1:0] mem_addr;

   // Memory-sourced results come straight from the synchronous read register.
   assign wpc_out = (sel_q == WB_MEM) ? rd_data_q : wpc_q;

   // Operand fetch, optionally replacing stale register values with the result in flight.
   always_comb begin
      op_a     = bus.in_PRA;
      op_b_reg = bus.in_PRB;
`ifdef EX_WB_FWD_EN
      if (w_rb_q && (bus.in_RA == wc_q)) op_a     = wpc_out;
      if (w_rb_q && (bus.in_RB == wc_q)) op_b_reg = wpc_out;
`endif
   end

`ifndef EX_WB_FWD_EN
   logic [7:0] unused_reg_idx;
   assign unused_reg_idx = {bus.in_RA, bus.in_RB};
`endif

   assign op_b     = bus.in_S_MXSE ? bus.in_se_out : op_b_reg;
   assign mem_addr = op_a[DMEM_AW-1:0];

   alu32 u_alu (
      .op       (bus.in_OP_ALU),
      .a        (op_a),
      .b        (op_b),
      .result   (alu_res),
      .flags    (alu_flags),
      .op_known (alu_known)
   );

   // Writeback value for the non-memory selects.
   always_comb begin
      wb_data = '0;
      case (wb_sel_e'(bus.in_S_MXRB))
         WB_ALU:  wb_data = alu_res;
         WB_PC1:  wb_data = bus.in_PC + 32'd1;
         WB_IMM:  wb_data = bus.in_se_out;
         default: wb_data = '0;
      endcase
   end

   // Next-state: capture on valid instructions, hold everything but the enable on bubbles.
   always_comb begin
      flags_d   = flags_q;
      wpc_d     = wpc_q;
      wc_d      = wc_q;
      sel_d     = sel_q;
      rd_data_d = rd_data_q;
      w_rb_d    = bus.in_valid & bus.in_W_RB;
      if (bus.in_valid) begin
         wpc_d     = wb_data;
         wc_d      = bus.in_WC;
         sel_d     = wb_sel_e'(bus.in_S_MXRB);
         rd_data_d = mem[mem_addr];
         if (alu_known) flags_d = alu_flags;
      end
   end

   // Stage result registers, cleared asynchronously.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         flags_q   <= '0;
         wpc_q     <= '0;
         wc_q      <= '0;
         w_rb_q    <= 1'b0;
         sel_q     <= WB_ALU;
         rd_data_q <= '0;
      end else begin
         flags_q   <= flags_d;
         wpc_q     <= wpc_d;
         wc_q      <= wc_d;
         w_rb_q    <= w_rb_d;
         sel_q     <= sel_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Data memory write port; contents survive reset but no write lands while it is held.
   always_ff @(posedge CLK) begin
      if (RESET && bus.in_valid && bus.in_W_DM) mem[mem_addr] <= op_b_reg;
   end

   assign bus.out_flags = flags_q;
   assign bus.out_WPC   = wpc_out;
   assign bus.out_WC    = wc_q;
   assign bus.out_W_RB  = w_rb_q;

endmodule

// File: tb/tb_ex_wb.sv
// tb/tb_ex_wb.sv - directed self-checking bench for ex_wb
module tb_ex_wb;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   ex_wb_if bus();

   ex_wb u_dut (
      .CLK   (clk),
      .RESET (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  flags;
      logic [3:0]  mask;
   } alu_vec_t;

   alu_vec_t vecs[$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] pra,
                        input logic [31:0] prb, input logic mxse, input logic [31:0] se,
                        input logic [1:0] sel, input logic wdm, input logic wrb,
                        input logic [3:0] wc);
      bus.in_valid  = v;
      bus.in_OP_ALU = op;
      bus.in_PRA    = pra;
      bus.in_PRB    = prb;
      bus.in_S_MXSE = mxse;
      bus.in_se_out = se;
      bus.in_S_MXRB = sel;
      bus.in_W_DM   = wdm;
      bus.in_W_RB   = wrb;
      bus.in_WC     = wc;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic v, input logic [4:0] op, input logic [31:0] pra,
                        input logic [31:0] prb, input logic mxse, input logic [31:0] se,
                        input logic [1:0] sel, input logic wdm, input logic wrb,
                        input logic [3:0] wc);
      drive(v, op, pra, prb, mxse, se, sel, wdm, wrb, wc);
      tick();
   endtask

   task automatic check_outs(input string tag, input logic [31:0] wpc, input logic [3:0] wc,
                             input logic wrb, input logic [3:0] flags);
      check({tag, ".wpc"},   bus.out_WPC, wpc);
      check({tag, ".wc"},    {28'd0, bus.out_WC}, {28'd0, wc});
      check({tag, ".w_rb"},  {31'd0, bus.out_W_RB}, {31'd0, wrb});
      check({tag, ".flags"}, {28'd0, bus.out_flags}, {28'd0, flags});
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus.in_PC = 32'd0;
      bus.in_RA = 4'hF;
      bus.in_RB = 4'hF;
      drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 4'd0);
      #1;
      check_outs("reset", 32'd0, 4'd0, 1'b0, 4'b0000);
      tick();
      tick();
      rst_n = 1'b1;

      // carry out of 0xFFFFFFFF + 1: Z and C set
      issue(1'b1, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 2'b00, 1'b0, 1'b1, 4'd3);
      check_outs("add_wrap", 32'd0, 4'd3, 1'b1, 4'b1100);

      // 0x80000000 - 1 overflows: O=1, S=0, Z=0 (C not constrained)
      issue(1'b1, 5'd5, 32'h8000_0000, 32'd0, 1'b1, 32'd1, 2'b00, 1'b0, 1'b1, 4'd4);
      check("sub_ovf.wpc", bus.out_WPC, 32'h7FFF_FFFF);
      check("sub_ovf.flags", {28'd0, bus.out_flags & 4'b1011}, 32'h0000_0001);

      vecs.push_back('{"and",    5'd11, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 4'b0000, 4'b1111});
      vecs.push_back('{"or",     5'd17, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 4'b0010, 4'b1111});
      vecs.push_back('{"xor",    5'd16, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 4'b1000, 4'b1111});
      vecs.push_back('{"lsl",    5'd8,  32'hC000_0001, 32'h0000_0000, 32'h8000_0002, 4'b0010, 4'b1111});
      vecs.push_back('{"asr",    5'd9,  32'h8000_0004, 32'h0000_0000, 32'hC000_0002, 4'b0010, 4'b1111});
      vecs.push_back('{"addinc", 5'd1,  32'h0000_0002, 32'h0000_0003, 32'h0000_0006, 4'b0000, 4'b1111});
      vecs.push_back('{"deca",   5'd6,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0010, 4'b1011});
      vecs.push_back('{"inca",   5'd3,  32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000, 4'b0011, 4'b1111});
      vecs.push_back('{"zeros",  5'd10, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 4'b1000, 4'b1111});
      vecs.push_back('{"passb",  5'd13, 32'h8000_0000, 32'h0000_0009, 32'h0000_0009, 4'b0000, 4'b1111});
      vecs.push_back('{"add_ov", 5'd0,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b1101, 4'b1111});
      vecs.push_back('{"sub_eq", 5'd5,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1000, 4'b1011});
      vecs.push_back('{"passa",  5'd15, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 4'b0010, 4'b1111});
      foreach (vecs[i]) begin
         issue(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 32'd0, 2'b00, 1'b0, 1'b1, 4'd1);
         check({vecs[i].name, ".wpc"}, bus.out_WPC, vecs[i].res);
         check({vecs[i].name, ".flags"}, {28'd0, bus.out_flags & vecs[i].mask},
               {28'd0, vecs[i].flags & vecs[i].mask});
      end

      // unlisted code passes A and leaves flags from PASSA (S only)
      issue(1'b1, 5'd2, 32'd0, 32'd7, 1'b0, 32'd0, 2'b00, 1'b0, 1'b1, 4'd1);
      check("unlisted.wpc", bus.out_WPC, 32'd0);
      check("unlisted.flags", {28'd0, bus.out_flags}, 32'h0000_0002);

      bus.in_PC = 32'h0000_0100;
      issue(1'b1, 5'd15, 32'd0, 32'd0, 1'b0, 32'd0, 2'b10, 1'b0, 1'b1, 4'd5);
      check("pc_plus1.wpc", bus.out_WPC, 32'h0000_0101);
      issue(1'b1, 5'd15, 32'd0, 32'd0, 1'b0, 32'h0000_ABCD, 2'b11, 1'b0, 1'b1, 4'd6);
      check("imm.wpc", bus.out_WPC, 32'h0000_ABCD);

      // store then load from the next instruction
      issue(1'b1, 5'd15, 32'd5, 32'h0000_CAFE, 1'b0, 32'd0, 2'b00, 1'b1, 1'b0, 4'd0);
      check("store.w_rb", {31'd0, bus.out_W_RB}, 32'd0);
      issue(1'b1, 5'd15, 32'd5, 32'd0, 1'b0, 32'd0, 2'b01, 1'b0, 1'b1, 4'd7);
      check_outs("load", 32'h0000_CAFE, 4'd7, 1'b1, 4'b0000);

      // bubble: no memory write, no writeback, everything held
      issue(1'b0, 5'd0, 32'd5, 32'h0000_DEAD, 1'b0, 32'd0, 2'b00, 1'b1, 1'b1, 4'd8);
      check_outs("bubble", 32'h0000_CAFE, 4'd7, 1'b0, 4'b0000);
      issue(1'b1, 5'd15, 32'd5, 32'd0, 1'b0, 32'd0, 2'b01, 1'b0, 1'b1, 4'd7);
      check("reload.wpc", bus.out_WPC, 32'h0000_CAFE);

      // reset asserted mid-cycle while a store is presented
      issue(1'b1, 5'd9, 32'h8000_0006, 32'h0000_1111, 1'b0, 32'd0, 2'b00, 1'b1, 1'b1, 4'd9);
      check_outs("pre_rst", 32'hC000_0003, 4'd9, 1'b1, 4'b0010);
      drive(1'b1, 5'd9, 32'h8000_0006, 32'h0000_2222, 1'b0, 32'd0, 2'b00, 1'b1, 1'b1, 4'd9);
      rst_n = 1'b0;
      #1;
      check_outs("rst_async", 32'd0, 4'd0, 1'b0, 4'b0000);
      tick();
      check("rst_held.w_rb", {31'd0, bus.out_W_RB}, 32'd0);
      rst_n = 1'b1;
      issue(1'b1, 5'd15, 32'd6, 32'd0, 1'b0, 32'd0, 2'b01, 1'b0, 1'b1, 4'd10);
      check("rst_store_blocked.wpc", bus.out_WPC, 32'h0000_1111);

      // back-to-back dependent pair; forwarding decides what the stale operand yields
      issue(1'b1, 5'd3, 32'd7, 32'd0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b1, 4'd2);
      check("fwd_src.wpc", bus.out_WPC, 32'd8);
      bus.in_RA = 4'd2;
      issue(1'b1, 5'd0, 32'd0, 32'd1, 1'b0, 32'd0, 2'b00, 1'b0, 1'b1, 4'd11);
`ifdef EX_WB_FWD_EN
      check("fwd_dst.wpc", bus.out_WPC, 32'd9);
`else
      check("fwd_dst.wpc", bus.out_WPC, 32'd1);
`endif
      bus.in_RA = 4'hF;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_wb.md
EX_WB -- requirements
Module: ex_wb

Interface
REQ-001 SHALL have: CLK  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: RESET  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: in_valid  in  1  decoded instruction present this cycle.
REQ-004 SHALL have: in_PRA, in_PRB  in  32 each  register operands A/B.
REQ-005 SHALL have: in_se_out  in  32  sign/zero-extended immediate.
REQ-006 SHALL have: in_PC  in  32  address of the instruction.
REQ-007 SHALL have: in_RA, in_RB, in_WC  in  4 each  source and destination register indices.
REQ-008 SHALL have: in_S_MXSE  in  1  operand-B select, 0=in_PRB, 1=in_se_out.
REQ-009 SHALL have: in_OP_ALU  in  5  ALU operation code.
REQ-010 SHALL have: in_W_DM  in  1  data-memory write.
REQ-011 SHALL have: in_S_MXRB  in  2  writeback select.
REQ-012 SHALL have: in_W_RB  in  1  register-bank write request.
REQ-013 SHALL have: out_flags  out  4  {Z,C,S,O}; bit0=O, bit1=S, bit2=C, bit3=Z.
REQ-014 SHALL have: out_WPC  out  32  writeback data.
REQ-015 SHALL have: out_WC  out  4  writeback register index.
REQ-016 SHALL have: out_W_RB  out  1  writeback enable.

Function
REQ-017 SHALL compute the ALU result combinationally from operand A = in_PRA and operand B = the MXSE choice.
REQ-018 SHALL support these ALU codes: 00 ADD, 01 ADDINC (A+B+1), 03 INCA, 05 SUB, 06 DECA, 08 LSL (A<<1), 09 ASR (A>>>1), 10 ZEROS, 11 AND, 13 PASSB, 15 PASSA, 16 XOR, 17 OR.
REQ-019 SHALL treat any other ALU code as PASSA and leave the flags unchanged.
REQ-020 SHALL compute arithmetic modulo 2^32.
REQ-021 SHALL derive flags as: C = carry-out; O = signed overflow; S = result[31]; Z = result==0.
REQ-022 SHALL clear C and O for logic and shift codes.
REQ-023 SHALL write the flags register on the edge where in_valid=1 and the code is listed in REQ-018.
REQ-024 SHALL make out_flags register outputs that are visible one cycle after the edge that captures them.
REQ-025 SHALL contain a 1024x32 data memory with address in_PRA[9:0] and write data in_PRB.
REQ-026 SHALL write the data memory on the edge where in_valid=1 and in_W_DM=1.
REQ-027 SHALL read the data memory synchronously.
REQ-028 SHALL return new data from a read that follows a write to the same address in the next instruction.
REQ-029 SHALL use writeback select codes 00 ALU result, 01 memory read data, 10 in_PC+1, 11 in_se_out.
REQ-030 SHALL register out_WPC, out_WC and out_W_RB, with latency exactly 1 cycle from the capture edge.
REQ-031 SHALL set out_W_RB = in_valid & in_W_RB.
REQ-032 SHALL set out_W_RB=0 and hold out_WPC and out_WC when in_valid=0 (bubble).
REQ-033 SHALL, for back-to-back valid instructions, update every output each cycle with no stall.

Reset
REQ-034 SHALL, on RESET low, immediately clear out_flags=0, out_WPC=0, out_WC=0 and out_W_RB=0.
REQ-035 SHALL suppress any data-memory write while RESET is low.
REQ-036 SHALL NOT reset the data-memory contents.
REQ-037 SHALL treat the first edge after reset release as a normal capture edge.

Configuration
REQ-038 SHALL use the macro EX_WB_FWD_EN to select forwarding.
REQ-039 SHALL, when EX_WB_FWD_EN is defined and out_W_RB=1, substitute out_WPC for in_PRA when in_RA==out_WC, and for in_PRB when in_RB==out_WC.
REQ-040 SHALL apply that substitution to both the ALU operands and the memory address/data.
REQ-041 SHALL, when EX_WB_FWD_EN is undefined, use operands unmodified and ignore in_RA and in_RB.

Structure
REQ-042 SHALL take ALU codes, writeback select codes and flag bit indices from shared package processor_pkg.
REQ-043 SHALL implement the ALU and flag generation as sub-module alu32.
REQ-044 SHALL keep the memory, registers and forwarding in ex_wb.

Verification
REQ-045 SHALL cover: ADD, PRA=0xFFFFFFFF, PRB=1, MXSE=0, S_MXRB=00, W_RB=1, WC=3 -> next cycle out_WPC=0, out_W_RB=1, out_WC=3, out_flags=4'b1100.
REQ-046 SHALL cover: SUB, PRA=0x80000000, MXSE=1, se_out=1 -> out_WPC=0x7FFFFFFF, O=1, S=0, Z=0.
REQ-047 SHALL cover: store PRA=5, PRB=0xCAFE, W_DM=1, then load PRA=5, S_MXRB=01 -> out_WPC=0xCAFE.
REQ-048 SHALL cover: in_valid=0 with W_DM=1, W_RB=1 -> memory unchanged, out_W_RB=0, flags held.
REQ-049 SHALL cover: RESET low mid-stream with a store pending -> outputs 0 at once and the store suppressed.
REQ-050 SHALL cover, with EX_WB_FWD_EN: INCA WC=2 from PRA=7, then ADD RA=2, stale PRA=0, PRB=1 -> out_WPC=9.
